// File: rtl/alu_2_ram_reader_if.sv
// Control AXI-Stream beat bundle (no tready) used on the stage control chain.
interface alu_2_ram_reader_if #(
    parameter int DATA_W = 256,
    parameter int USER_W = 128
);
    logic [DATA_W-1:0]   tdata;
    logic [USER_W-1:0]   tuser;
    logic [DATA_W/8-1:0] tkeep;
    logic                tvalid;
    logic                tlast;

    modport master (output tdata, tuser, tkeep, tvalid, tlast);
    modport slave  (input  tdata, tuser, tkeep, tvalid, tlast);
endinterface

// File: rtl/alu_2_ram_reader.sv
// Inline control-chain read responder for the stage ALU key-value RAM (fixed 4-cycle latency).
// Optional macro ALU2_RSP_CNT_EN adds a 16-bit response counter carried in tdata[79:64].
module alu_2_ram_reader #(
    parameter int STAGE_ID             = 0,
    parameter int RESOURCE_ID          = 2,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int ADDR_WIDTH           = 5,
    parameter int DATA_WIDTH           = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_2_ram_reader_if.slave     c_s_axis,
    alu_2_ram_reader_if.master    c_m_axis,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data
);
    localparam int KEEP_W = C_S_AXIS_DATA_WIDTH / 8;

    typedef struct packed {
        logic [C_S_AXIS_DATA_WIDTH-1:0]  tdata;
        logic [C_S_AXIS_TUSER_WIDTH-1:0] tuser;
        logic [KEEP_W-1:0]               tkeep;
        logic                            tlast;
    } beat_t;

    typedef enum logic [1:0] {WAIT_FIRST, SECOND, REST} state_t;

    function automatic beat_t make_rsp(input beat_t b, input logic [DATA_WIDTH-1:0] word);
        beat_t r;
        r = b;
        r.tdata[63:32] = 32'(word);
        r.tdata[15:8]  = 8'h81;
        return r;
    endfunction

    state_t                state_q, state_d;
    beat_t                 beat_p0_q, beat_p1_q, beat_p2_q, beat_p3_q;
    beat_t                 beat_p0_d, beat_p1_d, beat_p2_d, beat_p3_d;
    logic                  vld_p0_q, vld_p1_q, vld_p2_q, vld_p3_q;
    logic                  vld_p0_d, vld_p1_d, vld_p2_d, vld_p3_d;
    logic                  hit_p0_q, hit_p1_q, hit_p2_q, hit_p3_q;
    logic                  hit_p0_d, hit_p1_d, hit_p2_d, hit_p3_d;
    beat_t                 out_beat_q, out_beat_d;
    logic                  out_vld_q, out_vld_d;
    logic                  rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
`ifdef ALU2_RSP_CNT_EN
    logic [15:0]           cnt_q, cnt_d;
`endif

    always_comb begin
        state_d = state_q;
        if (c_s_axis.tvalid) begin
            unique case (state_q)
                WAIT_FIRST: state_d = c_s_axis.tlast ? WAIT_FIRST : SECOND;
                default:    state_d = c_s_axis.tlast ? WAIT_FIRST : REST;
            endcase
        end

        // Stage 0: capture the beat and classify it as a read hit
        beat_p0_d.tdata = c_s_axis.tdata;
        beat_p0_d.tuser = c_s_axis.tuser;
        beat_p0_d.tkeep = c_s_axis.tkeep;
        beat_p0_d.tlast = c_s_axis.tlast;
        vld_p0_d        = c_s_axis.tvalid;
        hit_p0_d        = c_s_axis.tvalid && (state_q == SECOND)
                          && (c_s_axis.tdata[7:3] == 5'(STAGE_ID))
                          && (c_s_axis.tdata[2:0] == 3'(RESOURCE_ID))
                          && (c_s_axis.tdata[15:8] == 8'h01);

        // Stage 1: issue the RAM read; address holds until the next hit
        beat_p1_d = beat_p0_q;
        vld_p1_d  = vld_p0_q;
        hit_p1_d  = hit_p0_q;
        rd_en_d   = hit_p0_q;
        rd_addr_d = hit_p0_q ? beat_p0_q.tdata[16 +: ADDR_WIDTH] : rd_addr_q;

        // Stages 2-3: wait out the RAM read latency
        beat_p2_d = beat_p1_q;
        vld_p2_d  = vld_p1_q;
        hit_p2_d  = hit_p1_q;
        beat_p3_d = beat_p2_q;
        vld_p3_d  = vld_p2_q;
        hit_p3_d  = hit_p2_q;

        // Stage 4: rd_data is valid now; rewrite the hit beat as the response
        out_vld_d  = vld_p3_q;
        out_beat_d = beat_p3_q;
`ifdef ALU2_RSP_CNT_EN
        cnt_d = cnt_q;
`endif
        if (hit_p3_q) begin
            out_beat_d = make_rsp(beat_p3_q, rd_data);
`ifdef ALU2_RSP_CNT_EN
            out_beat_d.tdata[79:64] = cnt_q;
            cnt_d = cnt_q + 16'd1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= WAIT_FIRST;
            vld_p0_q   <= 1'b0;
            vld_p1_q   <= 1'b0;
            vld_p2_q   <= 1'b0;
            vld_p3_q   <= 1'b0;
            hit_p0_q   <= 1'b0;
            hit_p1_q   <= 1'b0;
            hit_p2_q   <= 1'b0;
            hit_p3_q   <= 1'b0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            out_vld_q  <= 1'b0;
            out_beat_q <= '0;
`ifdef ALU2_RSP_CNT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            vld_p0_q   <= vld_p0_d;
            vld_p1_q   <= vld_p1_d;
            vld_p2_q   <= vld_p2_d;
            vld_p3_q   <= vld_p3_d;
            hit_p0_q   <= hit_p0_d;
            hit_p1_q   <= hit_p1_d;
            hit_p2_q   <= hit_p2_d;
            hit_p3_q   <= hit_p3_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            out_vld_q  <= out_vld_d;
            out_beat_q <= out_beat_d;
`ifdef ALU2_RSP_CNT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    // Internal beat data is qualified by the valid bits, so it needs no reset
    always_ff @(posedge clk) begin
        beat_p0_q <= beat_p0_d;
        beat_p1_q <= beat_p1_d;
        beat_p2_q <= beat_p2_d;
        beat_p3_q <= beat_p3_d;
    end

    assign c_m_axis.tdata  = out_beat_q.tdata;
    assign c_m_axis.tuser  = out_beat_q.tuser;
    assign c_m_axis.tkeep  = out_beat_q.tkeep;
    assign c_m_axis.tlast  = out_beat_q.tlast;
    assign c_m_axis.tvalid = out_vld_q;
    assign rd_en           = rd_en_q;
    assign rd_addr         = rd_addr_q;
endmodule

// File: doc/alu_2_ram_reader.md
Name: alu_2_ram_reader

Overview:
- Control-plane read responder for the stage ALU's key-value RAM. The ALU stores into this RAM; this block reads it back to software.
- Sits inline on the stage's control AXIS chain. Every control beat is forwarded with a fixed latency.
- When a read request addressed to this stage/resource arrives, the block fetches the RAM word and rewrites the packet in place as the response.
- Packets not addressed to this block pass through unchanged.

Parameters:
- STAGE_ID, 0, stage number matched against control packets (5 bits used).
- RESOURCE_ID, 2, resource number matched against control packets (3 bits used).
- C_S_AXIS_DATA_WIDTH, 256, control tdata width.
- C_S_AXIS_TUSER_WIDTH, 128, control tuser width.
- ADDR_WIDTH, 5, RAM address width.
- DATA_WIDTH, 32, RAM word width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- c_s_axis_tdata  in  C_S_AXIS_DATA_WIDTH  control beat data.
- c_s_axis_tuser  in  C_S_AXIS_TUSER_WIDTH  control beat user.
- c_s_axis_tkeep  in  C_S_AXIS_DATA_WIDTH/8  byte enables.
- c_s_axis_tvalid  in  1  beat valid; there is no tready, so every valid beat is accepted.
- c_s_axis_tlast  in  1  last beat of packet.
- c_m_axis_tdata  out  C_S_AXIS_DATA_WIDTH  forwarded/response data.
- c_m_axis_tuser  out  C_S_AXIS_TUSER_WIDTH  forwarded user.
- c_m_axis_tkeep  out  C_S_AXIS_DATA_WIDTH/8  forwarded keep.
- c_m_axis_tvalid  out  1  forwarded valid.
- c_m_axis_tlast  out  1  forwarded last.
- rd_en  out  1  RAM read strobe (dedicated read port).
- rd_addr  out  ADDR_WIDTH  RAM read address.
- rd_data  in  DATA_WIDTH  RAM read data, valid 2 cycles after rd_en.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is synchronous, active-low.
- Reset values: all c_m_axis_* = 0, rd_en = 0, rd_addr = 0, pipeline valids cleared, beat FSM in WAIT_FIRST.
- Latency: every input beat appears on c_m_axis exactly 4 cycles after acceptance. Order is preserved and all fields are unchanged except as stated below. Back-to-back beats are supported at full rate.
- Beat FSM, tracked at pipeline stage 0:
  - WAIT_FIRST: valid beat is beat0 (header). tlast=1 → stay; else → SECOND.
  - SECOND: valid beat is beat1, the command beat. tlast=1 → WAIT_FIRST; else → REST.
  - REST: tlast=1 → WAIT_FIRST.
  - tvalid=0 holds state.
- Beat1 fields:
  - tdata[7:3] = stage.
  - tdata[2:0] = resource.
  - tdata[15:8] = opcode.
  - tdata[15+ADDR_WIDTH+1-1:16] = address.
  - tdata[63:32] = data slot.
- Hit: beat1 with stage==STAGE_ID[4:0], resource==RESOURCE_ID[2:0] and opcode==8'h01.
- Cycle 1 after accepting a hit: rd_en=1 for exactly one cycle, rd_addr=address. rd_addr holds its value until the next hit.
- Cycle 3: rd_data is captured into the delayed beat.
- Cycle 4, output of the hit beat: tdata[63:32] = rd_data (zero-extended or truncated to 32 bits), tdata[15:8] = 8'h81. All other bits are unchanged.
- Non-hit beat1 (any mismatch, including opcode 8'h02 or others) passes through unchanged, and rd_en stays 0.
- Single-beat packets (tlast on beat0) never produce a hit.
- Hits in consecutive packets separated by one beat each are each serviced. Reads never overlap the 2-cycle window incorrectly, because one read is issued per pipeline slot.
- Reset mid-packet: in-flight beats are discarded (never emitted). The first valid beat after reset is treated as beat0.
- tvalid=0 bubbles propagate as tvalid=0 outputs. Data under an invalid output is don't-care but must not assert tvalid.

Optional Feature:
- ALU2_RSP_CNT_EN:
  - Defined: a 16-bit counter increments on each hit (wraps 16'hFFFF→0, reset to 0). The response beat additionally carries the pre-increment count in tdata[79:64].
  - Undefined: tdata[79:64] passes through unchanged and no counter exists.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with tvalid=1 → all outputs 0. After release, first beat is treated as beat0.
- Read hit with STAGE_ID=3, RESOURCE_ID=2, RAM[5]=32'hDEADBEEF:
  - Stimulus: beat0, then beat1 with tdata[7:0]=8'h1A, opcode 01, addr 5, tlast=1.
  - Response: rd_en pulse with rd_addr=5 one cycle after beat1. Output beat1 four cycles after input has tdata[63:32]=32'hDEADBEEF and tdata[15:8]=8'h81; beat0 is bit-identical.
- Misses, each with rd_en never asserted and output bit-identical:
  - stage mismatch (tdata[7:3]=4);
  - opcode 8'h02;
  - single-beat packet with a matching beat0.
- Back-to-back: two 2-beat hit packets, no gaps, addresses 1 and 2 (RAM 32'h11, 32'h22) → two rd_en pulses 2 cycles apart. Responses carry 32'h11 then 32'h22. tvalid is continuous on output.
- Mid-packet reset: assert rst_n=0 after beat1 of a 4-beat packet → no beats of that packet are emitted. A fresh hit packet afterwards responds correctly.
- ALU2_RSP_CNT_EN defined: three hits → tdata[79:64] = 0, 1, 2. A preloaded count of 16'hFFFF wraps to 0 on the next hit.
